// File: rtl/scan_dec_pkg.sv
// scan_dec_pkg: mode codes and FSM state type shared by the scan decoder
package scan_dec_pkg;
  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_SCAN_ONCE = 2'b01;
  localparam logic [1:0] MODE_SCAN_LOOP = 2'b10;
  typedef enum logic {IDLE, SCAN} state_t;
endpackage

// File: rtl/scan_decoder_onehot_dec.sv
// onehot_dec: combinational SEL_W-to-2**SEL_W one-hot decoder; idx_i index, en_i enable, d_o one-hot (all 0 when disabled)
module onehot_dec #(
  parameter int SEL_W = 3,
  localparam int OUT_W = 2**SEL_W
) (
  input  logic [SEL_W-1:0] idx_i,
  input  logic             en_i,
  output logic [OUT_W-1:0] d_o
);
  always_comb d_o = OUT_W'(en_i) << idx_i;
endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: registered one-hot decoder with once/loop scan; in clk,rst,en,mode,sel,start,stop; out d,idx,busy,done
module scan_decoder
  import scan_dec_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int DWELL = 1,
  parameter bit ACTIVE_LOW = 1'b0,
  localparam int OUT_W = 2**SEL_W,
  localparam int CNT_W = $clog2(DWELL) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             start,
  input  logic             stop,
  output logic [OUT_W-1:0] d,
  output logic [SEL_W-1:0] idx,
  output logic             busy,
  output logic             done
);
  state_t state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] d_q, d_d, dec;
  logic busy_q, done_q, done_d, dec_en, scan_req, last, fin;
  always_comb begin
    scan_req = mode == MODE_SCAN_ONCE || mode == MODE_SCAN_LOOP;
    last = cnt_q == CNT_W'(DWELL - 1);
    fin = mode_q == MODE_SCAN_ONCE && idx_q == SEL_W'(OUT_W - 1);
    state_d = state_q;
    mode_d = mode_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    dec_en = 1'b0;
    if (state_q == IDLE) begin
      if (start && !stop && scan_req) begin
        state_d = SCAN;
        mode_d = mode;
        idx_d = sel;
        cnt_d = '0;
        dec_en = en;
      end else if (!scan_req) begin
        idx_d = sel;
        dec_en = en;
      end
    end else if (stop) begin
      state_d = IDLE;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_q + CNT_W'(1);
      if (last && fin) begin
        state_d = IDLE;
        done_d = 1'b1;
      end else begin
        idx_d = last ? idx_q + SEL_W'(1) : idx_q;
        dec_en = 1'b1;
      end
    end
    d_d = dec ^ {OUT_W{ACTIVE_LOW}};
  end
  onehot_dec #(.SEL_W(SEL_W)) u_dec (.idx_i(idx_d), .en_i(dec_en), .d_o(dec));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q <= MODE_DIRECT;
      idx_q <= '0;
      cnt_q <= '0;
      d_q <= {OUT_W{ACTIVE_LOW}};
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      d_q <= d_d;
      busy_q <= state_d == SCAN;
      done_q <= done_d;
    end
  end
  assign d = d_q;
  assign idx = idx_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: three decoder configurations checked against an elapsed-time scan model plus literal expectations
module tb_scan_decoder;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, start = 1'b0, stop = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] sel = 4'd0;
  logic [7:0] d_a, d_c;
  logic [15:0] d_b;
  logic [2:0] idx_a, idx_c;
  logic [3:0] idx_b;
  logic busy_a, busy_b, busy_c, done_a, done_b, done_c;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  scan_decoder #(.SEL_W(3), .DWELL(2), .ACTIVE_LOW(1'b0)) u_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel[2:0]), .start(start), .stop(stop),
    .d(d_a), .idx(idx_a), .busy(busy_a), .done(done_a));
  scan_decoder #(.SEL_W(4), .DWELL(4), .ACTIVE_LOW(1'b1)) u_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .start(start), .stop(stop),
    .d(d_b), .idx(idx_b), .busy(busy_b), .done(done_b));
  scan_decoder #(.SEL_W(3), .DWELL(1), .ACTIVE_LOW(1'b0)) u_c (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel[2:0]), .start(start), .stop(stop),
    .d(d_c), .idx(idx_c), .busy(busy_c), .done(done_c));
  function automatic int nw(int k);
    return k == 1 ? 16 : 8;
  endfunction
  function automatic int dw(int k);
    return k == 0 ? 2 : k == 1 ? 4 : 1;
  endfunction
  function automatic logic [15:0] inact(int k);
    return k == 1 ? 16'hFFFF : 16'h0000;
  endfunction
  function automatic logic [15:0] drive(int k, int i);
    return (16'(1) << i) ^ inact(k);
  endfunction
  function automatic logic [15:0] act_d(int k);
    return k == 0 ? {8'h00, d_a} : k == 1 ? d_b : {8'h00, d_c};
  endfunction
  function automatic int act_idx(int k);
    return k == 0 ? int'(idx_a) : k == 1 ? int'(idx_b) : int'(idx_c);
  endfunction
  function automatic logic act_busy(int k);
    return k == 0 ? busy_a : k == 1 ? busy_b : busy_c;
  endfunction
  function automatic logic act_done(int k);
    return k == 0 ? done_a : k == 1 ? done_b : done_c;
  endfunction
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  bit m_busy[3], m_once[3], m_done[3], m_idx_ok[3];
  int m_s[3], m_e[3], m_idx[3];
  logic [15:0] m_d[3];
  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_busy[k] = 1'b0;
        m_done[k] = 1'b0;
        m_d[k] = inact(k);
        m_idx[k] = 0;
        m_idx_ok[k] = 1'b1;
      end else begin
        m_done[k] = 1'b0;
        if (m_busy[k]) begin
          if (stop) begin
            m_busy[k] = 1'b0;
            m_d[k] = inact(k);
            m_idx_ok[k] = 1'b0;
          end else if (!en) begin
            m_d[k] = inact(k);
          end else begin
            m_e[k]++;
            if (m_once[k] && m_e[k] == (nw(k) - m_s[k]) * dw(k)) begin
              m_busy[k] = 1'b0;
              m_done[k] = 1'b1;
              m_d[k] = inact(k);
              m_idx_ok[k] = 1'b0;
            end else begin
              m_idx[k] = (m_s[k] + m_e[k] / dw(k)) % nw(k);
              m_d[k] = drive(k, m_idx[k]);
            end
          end
        end else if (start && !stop && (mode == 2'b01 || mode == 2'b10)) begin
          m_busy[k] = 1'b1;
          m_once[k] = mode == 2'b01;
          m_s[k] = int'(sel) % nw(k);
          m_e[k] = 0;
          m_idx[k] = m_s[k];
          m_idx_ok[k] = 1'b1;
          m_d[k] = en ? drive(k, m_s[k]) : inact(k);
        end else if (mode == 2'b00 || mode == 2'b11) begin
          m_idx[k] = int'(sel) % nw(k);
          m_idx_ok[k] = 1'b1;
          m_d[k] = en ? drive(k, m_idx[k]) : inact(k);
        end else begin
          m_d[k] = inact(k);
          m_idx_ok[k] = 1'b0;
        end
      end
    end
  end
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("model_d%0d", k), act_d(k), m_d[k]);
      chk($sformatf("model_busy%0d", k), 16'(act_busy(k)), 16'(m_busy[k]));
      chk($sformatf("model_done%0d", k), 16'(act_done(k)), 16'(m_done[k]));
      if (m_idx_ok[k]) chk($sformatf("model_idx%0d", k), 16'(act_idx(k)), 16'(m_idx[k]));
    end
  end
  logic [7:0] once_seq[7] = '{8'h20, 8'h20, 8'h40, 8'h40, 8'h80, 8'h80, 8'h00};
  initial begin
    int nb, nd;
    tick;
    tick;
    chk("rst_d_a", 16'(d_a), 16'h0000);
    chk("rst_d_b", d_b, 16'hFFFF);
    chk("rst_busy_b", 16'(busy_b), 16'h0);
    chk("rst_idx_a", 16'(idx_a), 16'h0);
    rst = 1'b0;
    mode = 2'b00;
    sel = 4'd3;
    tick;
    chk("direct_en0", 16'(d_a), 16'h0000);
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = 4'(i);
      tick;
      chk("direct_a", 16'(d_a), 16'(1) << i);
    end
    sel = 4'd9;
    tick;
    chk("direct_b_al", d_b, 16'hFDFF);
    mode = 2'b01;
    sel = 4'd5;
    start = 1'b1;
    nb = 0;
    nd = 0;
    for (int i = 0; i < 7; i++) begin
      tick;
      start = 1'b0;
      chk("once_seq", 16'(d_a), 16'(once_seq[i]));
      nb += int'(busy_a);
      nd += int'(done_a);
    end
    chk("once_busy_cycles", 16'(nb), 16'd6);
    chk("once_done_pulses", 16'(nd), 16'd1);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    mode = 2'b10;
    sel = 4'd6;
    start = 1'b1;
    nd = 0;
    tick;
    start = 1'b0;
    chk("loop_idx6", 16'(idx_c), 16'd6);
    tick;
    nd += int'(done_c);
    chk("loop_idx7", 16'(idx_c), 16'd7);
    tick;
    nd += int'(done_c);
    chk("loop_idx0", 16'(idx_c), 16'd0);
    tick;
    nd += int'(done_c);
    chk("loop_idx1", 16'(idx_c), 16'd1);
    stop = 1'b1;
    tick;
    nd += int'(done_c);
    stop = 1'b0;
    chk("loop_stop_d", 16'(d_c), 16'h0000);
    chk("loop_stop_busy", 16'(busy_c), 16'h0);
    chk("loop_no_done", 16'(nd), 16'd0);
    mode = 2'b01;
    sel = 4'd2;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("gap_start_d", d_b, 16'hFFFB);
    tick;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("gap_d_inactive", d_b, 16'hFFFF);
      chk("gap_idx_hold", 16'(idx_b), 16'd2);
    end
    en = 1'b1;
    tick;
    chk("gap_resume_d", d_b, 16'hFFFB);
    tick;
    chk("gap_resume_idx", 16'(idx_b), 16'd2);
    tick;
    chk("gap_advance_idx", 16'(idx_b), 16'd3);
    chk("gap_advance_d", d_b, 16'hFFF7);
    stop = 1'b1;
    tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    stop = 1'b0;
    chk("start_stop_a", 16'(busy_a), 16'h0);
    chk("start_stop_b", 16'(busy_b), 16'h0);
    mode = 2'b10;
    sel = 4'd0;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    sel = 4'd4;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("restart_ignored_idx", 16'(idx_a), 16'd1);
    chk("restart_busy", 16'(busy_a), 16'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_d_a", 16'(d_a), 16'h0000);
    chk("async_d_b", d_b, 16'hFFFF);
    chk("async_busy_a", 16'(busy_a), 16'h0);
    chk("async_idx_a", 16'(idx_a), 16'h0);
    tick;
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      en = $urandom_range(0, 9) != 0;
      mode = 2'($urandom_range(0, 3));
      sel = 4'($urandom);
      start = $urandom_range(0, 7) == 0;
      stop = $urandom_range(0, 59) == 0;
      rst = $urandom_range(0, 499) == 0;
      tick;
    end
    rst = 1'b0;
    tick;
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
